// File: rtl/flopr_pipe_stage.sv
// One elastic pipeline slot: data word plus valid bit. Latency 1 cycle; capture on load,
// empty on drain or flush, otherwise hold (data of an empty slot keeps its last value).
module pipe_stage #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/flopr_pipe.sv
// Elastic register chain of DEPTH slots with bubble collapse; DEPTH-cycle latency when empty.
// Backpressure: in_ready drops only when every slot is full and the output is not consumed.
module flopr_pipe #(
  parameter int               WIDTH     = 64,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           d,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] stage_dat [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic             go;
  logic             accept;

  // Advance decisions ripple from the output back toward stage 0.
  always_comb begin
    go             = en & ~flush;
    adv            = '0;
    load           = '0;
    adv[DEPTH-1]   = go & vld[DEPTH-1] & out_ready;
    for (int i = DEPTH-2; i >= 0; i--) begin
      adv[i] = go & vld[i] & (~vld[i+1] | adv[i+1]);
    end
    in_ready = reset & go & (~vld[0] | adv[0]);
    accept   = in_valid & in_ready;
    load[0]  = accept;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] din;
    if (i == 0) begin : g_head
      assign din = d;
    end else begin : g_body
      assign din = stage_dat[i-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (load[i]),
      .drain (adv[i]),
      .d     (din),
      .q     (stage_dat[i]),
      .valid (vld[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(accept) - CW'(adv[DEPTH-1]);
    end
  end

  assign q         = stage_dat[DEPTH-1];
  assign out_valid = vld[DEPTH-1];

endmodule

// File: doc/flopr_pipe.md
FLOPR_PIPE -- requirements
Module: flopr_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (legal range 1..16).
REQ-003 SHALL have parameter RESET_VAL, default 0, the value loaded into every data stage on reset.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port en  input  1  global advance enable; 0 = hold all state.
REQ-007 SHALL have port flush  input  1  synchronous clear of all stage valids.
REQ-008 SHALL have port in_valid  input  1  upstream offers d.
REQ-009 SHALL have port in_ready  output  1  the block accepts d this cycle.
REQ-010 SHALL have port d  input  WIDTH  input data.
REQ-011 SHALL have port out_valid  output  1  the last stage holds valid data.
REQ-012 SHALL have port out_ready  input  1  downstream consumes q this cycle.
REQ-013 SHALL have port q  output  WIDTH  last-stage data.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-015 SHALL be an elastic chain of DEPTH stages, each holding a data word and a valid bit; stage DEPTH-1 drives q/out_valid.
REQ-016 SHALL define stage i as advancing when en=1, flush=0, stage i valid, and stage i+1 is empty or advancing; the last stage advances when en=1, flush=0, out_valid=1, out_ready=1.
REQ-017 SHALL drive in_ready = en and not flush and (stage 0 empty or stage 0 advancing), combinationally.
REQ-018 SHALL accept a word on the rising edge where in_valid=1 and in_ready=1, loading it into stage 0.
REQ-019 SHALL collapse bubbles: a valid stage moves forward whenever the next stage is empty, even if the output is stalled.
REQ-020 SHALL have a latency of DEPTH cycles through an empty chain: a word accepted at edge N is visible on q with out_valid=1 after edge N+DEPTH-1.
REQ-021 SHALL sustain one word per cycle when out_ready=1 continuously, preserving order, with no loss or duplication.
REQ-022 SHALL load a stage's data register only when that stage captures a word; data of empty stages holds its last value.
REQ-023 SHALL, on flush=1 at an edge, clear all valid bits and leave data registers unchanged; the offered input is not accepted; flush overrides en.
REQ-024 SHALL, with en=0 and flush=0, hold all valids and data, drive in_ready=0, and keep out_valid/q stable regardless of out_ready.
REQ-025 SHALL, when full (count=DEPTH) and out_ready=1, accept a new input in the same cycle.
REQ-026 SHALL drive count as the registered population of valid bits, consistent with the state after each edge.

Reset
REQ-027 SHALL, while reset=0, asynchronously force all valid bits to 0, all data stages to RESET_VAL, count=0, out_valid=0, q=RESET_VAL.
REQ-028 SHALL discard in-flight words when reset asserts mid-operation; the first edge after reset releases behaves as from an empty chain.
REQ-029 SHALL drive in_ready=0 while reset=0.

Structure
REQ-030 SHALL need no shared package; all widths derive from the module parameters.
REQ-031 SHALL use one sub-module, pipe_stage (WIDTH, RESET_VAL), holding one data word plus valid bit with async active-low reset, instantiated DEPTH times in a generate loop.

Verification (WIDTH=64, DEPTH=4)
REQ-032 SHALL check: reset=0 for 5 cycles, then in_valid=1, d=64'h1..64'hA on consecutive cycles, out_ready=1 -> q=64'h1 with out_valid=1 after the 4th edge, then 64'h2..64'hA in order, count stays 4 while streaming.
REQ-033 SHALL check: out_ready=0, push 64'h11..64'h14 -> count=4, in_ready=0, q=64'h11 held; then out_ready=1 with in_valid=1, d=64'h15 -> 64'h15 accepted in the same cycle.
REQ-034 SHALL check: one word 64'h22 followed by 3 idle cycles with out_ready=0 -> word reaches the last stage (bubble collapse), count=1.
REQ-035 SHALL check: three words in flight, flush=1 for one edge with in_valid=1, d=64'h33 -> count=0, out_valid=0, 64'h33 never appears on q.
REQ-036 SHALL check: en=0 for 3 cycles while full with out_ready=1 -> q, count and out_valid unchanged and in_ready=0; resumes in order when en=1.
REQ-037 SHALL check: reset pulsed low mid-stream between edges -> out_valid=0, count=0, q=RESET_VAL immediately, without waiting for a clock edge.
